// File: rtl/ram_arbiter.sv
// ram_arbiter
// Arbitrates NUM_PORTS requesters onto one single-ported RAM with a
// registered read (one-cycle latency). Open mode grants round-robin
// starting at rr_ptr; a transfer with req_lock set pins the grant to that
// port until it completes a transfer with req_lock clear.
//
// Ports:
//   clock, reset                  sole clock (rising edge), async active-high reset
//   req_valid/req_write/req_lock  per-port request, direction, keep-grant flag
//   req_address, req_data         packed per port, port p at [p*W +: W]
//   req_ready                     one-hot-or-zero accept strobe (combinational)
//   resp_valid, resp_data         read response one cycle after the transfer
//   ram_address, ram_write,
//   ram_in_data, ram_out_data     RAM connection
//   stall_count                   present only with RAM_ARBITER_STATS_EN defined:
//                                 saturating count of cycles in which some valid
//                                 port did not transfer
//
// Build option: `define RAM_ARBITER_STATS_EN to add stall_count.

module ram_arbiter #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NUM_PORTS     = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS-1:0]              req_lock,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]    req_data,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output logic [WORD_WIDTH-1:0]             resp_data,
  output logic [ADDRESS_WIDTH-1:0]          ram_address,
  output logic                              ram_write,
  output logic [WORD_WIDTH-1:0]             ram_in_data,
  input  logic [WORD_WIDTH-1:0]             ram_out_data
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [31:0]                       stall_count
`endif
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state_reg;
  logic [PW-1:0]          rr_ptr_reg;
  logic [PW-1:0]          owner_reg;
  logic [NUM_PORTS-1:0]   resp_valid_reg;

  logic                   grant_hit;
  logic [PW-1:0]          grant_idx;
  logic [PW-1:0]          cand;
  logic [PW-1:0]          next_ptr;

  logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    data_arr [NUM_PORTS];

  // Unpack the flat request buses and build the one-hot ready vector.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_arr[gi]  = req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign data_arr[gi]  = req_data[gi*WORD_WIDTH +: WORD_WIDTH];
      assign req_ready[gi] = grant_hit && (grant_idx == PW'(gi));
    end
  endgenerate

  // Grant selection. Reset forces "no grant" so the RAM sees an idle bus.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!reset) begin
      if (state_reg == LOCKED) begin
        // Other ports stall even when the owner is idle.
        grant_hit = req_valid[owner_reg];
        grant_idx = owner_reg;
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          cand = PW'((32'(rr_ptr_reg) + 32'(i)) % 32'(NUM_PORTS));
          if (!grant_hit && req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
  end

  assign next_ptr = PW'((32'(grant_idx) + 32'd1) % 32'(NUM_PORTS));

  // RAM drive: the granted request passes straight through; idle bus is all zero.
  always_comb begin
    ram_write   = 1'b0;
    ram_address = '0;
    ram_in_data = '0;
    if (grant_hit) begin
      ram_write   = req_write[grant_idx];
      ram_address = addr_arr[grant_idx];
      ram_in_data = data_arr[grant_idx];
    end
  end

  // The RAM's registered read lines up with resp_valid_reg, so read data is a
  // direct pass-through.
  assign resp_valid = resp_valid_reg;
  assign resp_data  = ram_out_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= OPEN;
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      resp_valid_reg <= '0;
    end else begin
      resp_valid_reg <= (grant_hit && !req_write[grant_idx]) ? req_ready : '0;
      if (grant_hit) begin
        if (state_reg == OPEN) begin
          // Taking a lock leaves rr_ptr where it was.
          if (req_lock[grant_idx]) begin
            state_reg <= LOCKED;
            owner_reg <= grant_idx;
          end else begin
            rr_ptr_reg <= next_ptr;
          end
        end else if (!req_lock[grant_idx]) begin
          state_reg  <= OPEN;
          rr_ptr_reg <= next_ptr;
        end
      end
    end
  end

`ifdef RAM_ARBITER_STATS_EN
  logic [31:0] stall_count_reg;
  logic        stall_any;

  assign stall_any   = |(req_valid & ~req_ready);
  assign stall_count = stall_count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (stall_any && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int NP = 4;
  localparam int AW = 10;
  localparam int WW = 32;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_write;
  logic [NP-1:0]     req_lock;
  logic [NP*AW-1:0]  req_address;
  logic [NP*WW-1:0]  req_data;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     resp_valid;
  logic [WW-1:0]     resp_data;
  logic [AW-1:0]     ram_address;
  logic              ram_write;
  logic [WW-1:0]     ram_in_data;
  logic [WW-1:0]     ram_out_data;
`ifdef RAM_ARBITER_STATS_EN
  logic [31:0]       stall_count;
`endif

  ram_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .NUM_PORTS(NP)) dut (
    .clock        (clk),
    .reset        (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_lock     (req_lock),
    .req_address  (req_address),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .ram_address  (ram_address),
    .ram_write    (ram_write),
    .ram_in_data  (ram_in_data),
    .ram_out_data (ram_out_data)
`ifdef RAM_ARBITER_STATS_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] init_word(input int i);
    if (i >= 16 && i <= 19) return WW'(32'hA0 + i - 16);
    return WW'(i) * 32'h0101_0101 ^ 32'h5A;
  endfunction

  // Environment RAM: single port, registered read, no read during a write.
  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic [WW-1:0] ram_rd;
  assign ram_out_data = ram_rd;
  initial begin
    ram_rd = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_write) mem[ram_address] <= ram_in_data;
      else           ram_rd <= mem[ram_address];
    end
  end

  // Behavioural reference: arbitration state, a shadow memory updated in
  // transfer order, and the read response expected on the next cycle.
  logic [WW-1:0] exp_mem [0:(1<<AW)-1];
  bit            m_locked = 0;
  int            m_owner  = 0;
  int            m_rr     = 0;
  int            m_pend   = -1;
  logic [WW-1:0] m_pend_data = '0;
  logic [31:0]   m_stall  = '0;
  int            m_g;
  bit            m_st;
  logic [AW-1:0] m_a;

  function automatic int model_grant();
    if (rst) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NP; k++) begin
      if (req_valid[(m_rr + k) % NP]) return (m_rr + k) % NP;
    end
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < (1<<AW); i++) exp_mem[i] = init_word(i);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_locked = 0; m_owner = 0; m_rr = 0; m_pend = -1; m_stall = '0;
      end else begin
        m_g  = model_grant();
        m_st = 0;
        for (int p = 0; p < NP; p++) if (req_valid[p] && p != m_g) m_st = 1;
        if (m_st && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        m_pend = -1;
        if (m_g >= 0) begin
          m_a = req_address[m_g*AW +: AW];
          if (req_write[m_g]) exp_mem[m_a] = req_data[m_g*WW +: WW];
          else begin
            m_pend      = m_g;
            m_pend_data = exp_mem[m_a];
          end
          if (!m_locked) begin
            if (req_lock[m_g]) begin m_locked = 1; m_owner = m_g; end
            else m_rr = (m_g + 1) % NP;
          end else if (!req_lock[m_g]) begin
            m_locked = 0;
            m_rr     = (m_g + 1) % NP;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  int c_g;
  always @(negedge clk) begin
    if (check_en) begin
      c_g = model_grant();
      chk("req_ready", 64'(req_ready), (c_g >= 0) ? 64'(1) << c_g : 64'd0);
      chk("ram_write", 64'(ram_write), (c_g >= 0) ? 64'(req_write[c_g]) : 64'd0);
      chk("ram_address", 64'(ram_address), (c_g >= 0) ? 64'(req_address[c_g*AW +: AW]) : 64'd0);
      chk("ram_in_data", 64'(ram_in_data), (c_g >= 0) ? 64'(req_data[c_g*WW +: WW]) : 64'd0);
      chk("resp_valid", 64'(resp_valid), (m_pend >= 0) ? 64'(1) << m_pend : 64'd0);
      if (m_pend >= 0) chk("resp_data", 64'(resp_data), 64'(m_pend_data));
`ifdef RAM_ARBITER_STATS_EN
      chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    end
  end

  task automatic drive(input int p, input logic v, input logic w, input logic l,
                       input logic [AW-1:0] a, input logic [WW-1:0] d);
    req_valid[p] = v;
    req_write[p] = w;
    req_lock[p]  = l;
    req_address[p*AW +: AW] = a;
    req_data[p*WW +: WW]    = d;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [NP-1:0] v;

  initial begin
    rst = 1;
    idle();
    step();
    check_en = 1;

    // Reset state with every port requesting: nothing may be granted.
    req_valid = '1;
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_ram_write", 64'(ram_write), 64'd0);
    chk("reset_ram_address", 64'(ram_address), 64'd0);
    step();

    // All four ports read 0x10..0x13 at once.
    rst = 0;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 1'b0, AW'(16 + p), '0);
    for (int k = 0; k <= NP; k++) begin
      v = 4'hF << k;
      req_valid = v;
      @(negedge clk);
      chk("rr_order_ready", 64'(req_ready), (k < NP) ? 64'(1) << k : 64'd0);
      if (k > 0) begin
        chk("rr_resp_valid", 64'(resp_valid), 64'(1) << (k - 1));
        chk("rr_resp_data", 64'(resp_data), 64'(32'hA0 + k - 1));
      end
      step();
    end

    // Write then read of the same address on consecutive cycles.
    idle();
    drive(2, 1'b1, 1'b1, 1'b0, 10'h005, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_ready", 64'(req_ready), 64'h4);
    chk("wr_ram_write", 64'(ram_write), 64'd1);
    step();
    idle();
    drive(1, 1'b1, 1'b0, 1'b0, 10'h005, '0);
    @(negedge clk);
    chk("rd_ready", 64'(req_ready), 64'h2);
    chk("wr_no_resp", 64'(resp_valid), 64'd0);
    step();
    idle();
    @(negedge clk);
    chk("raw_resp_valid", 64'(resp_valid), 64'h2);
    chk("raw_resp_data", 64'(resp_data), 64'hDEAD_BEEF);
    step();

    // Lock by port 3 while ports 0 and 1 keep requesting.
    drive(0, 1'b1, 1'b0, 1'b0, 10'h020, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 10'h021, '0);
    drive(3, 1'b1, 1'b0, 1'b1, 10'h030, '0);
    @(negedge clk);
    chk("lock_grant", 64'(req_ready), 64'h8);
    step();
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lock_stall", 64'(req_ready), 64'd0);
    chk("lock_resp_valid", 64'(resp_valid), 64'h8);
    step();
    @(negedge clk);
    chk("lock_stall2", 64'(req_ready), 64'd0);
    step();
    drive(3, 1'b1, 1'b1, 1'b0, 10'h030, 32'h1234_5678);
    @(negedge clk);
    chk("unlock_write", 64'(req_ready), 64'h8);
    step();
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("after_unlock", 64'(req_ready), 64'h1);
    step();
    idle();
    step();

    // Reset the cycle after a port-0 read transfer.
    drive(0, 1'b1, 1'b0, 1'b0, 10'h011, '0);
    @(negedge clk);
    chk("pre_reset_ready", 64'(req_ready), 64'h1);
    step();
    idle();
    rst = 1;
    @(negedge clk);
    chk("reset_drop_resp", 64'(resp_valid), 64'd0);
    step();
    rst = 0;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("post_reset_rr", 64'(req_ready), 64'h1);
    chk("post_reset_resp", 64'(resp_valid), 64'd0);
    step();
    idle();

    // Reset releases a lock held by port 1.
    drive(1, 1'b1, 1'b0, 1'b1, 10'h012, '0);
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("reset_unlock", 64'(req_ready), 64'h1);
    step();
    idle();
    step();

`ifdef RAM_ARBITER_STATS_EN
    rst = 1;
    step();
    rst = 0;
    req_valid = 4'b0011;
    repeat (10) step();
    idle();
    @(negedge clk);
    chk("stall_count_10", 64'(stall_count), 64'd10);
    step();
`endif

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < NP; p++)
        drive(p, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, AW'($urandom_range(0, 15)), $urandom);
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 0;
    idle();
    step();
    step();
    check_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
